threshold_ctrl: RTL

//  Adaptive threshold controller for the pixel binarisation stage. Measures mean

---
 rtl/threshold_ctrl_pkg.sv | 15 +
 rtl/threshold_ctrl_if.sv | 8 +
 rtl/threshold_ctrl_seq_divider.sv | 53 +++++
 rtl/threshold_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/threshold_ctrl_pkg.sv
// threshold_pkg: shared widths, defaults, FSM states and clamp helper for threshold_ctrl
package threshold_pkg;
    localparam int DATA_W = 10;
    localparam int CNT_W = 20;
    localparam int SUM_W = 30;
    localparam int DEF_THRESH = 190;
    localparam int MIN_PIX = 1024;

    typedef enum logic {IDLE, ACCUM} state_t;

    // t carries two guard bits: the top one flags negative, the next one overflow
    function automatic logic [DATA_W-1:0] clamp(logic signed [DATA_W+1:0] t);
        return t[DATA_W+1] ? '0 : t[DATA_W] ? '1 : t[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/threshold_ctrl_if.sv
// threshold_ctrl_if: pixel stream, host override and threshold outputs of threshold_ctrl
interface threshold_ctrl_if #(parameter int DW = threshold_pkg::DATA_W) ();
    logic iFVAL, iDVAL, iMANUAL, oUPDATE, oBUSY, oDROP;
    logic [DW-1:0] iDATA, iMAN_THRESH, oTHRESH;

    modport master(output iFVAL, iDVAL, iDATA, iMANUAL, iMAN_THRESH, input oTHRESH, oUPDATE, oBUSY, oDROP);
    modport slave(input iFVAL, iDVAL, iDATA, iMANUAL, iMAN_THRESH, output oTHRESH, oUPDATE, oBUSY, oDROP);
endinterface

// File: rtl/threshold_ctrl_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, SUM_W cycles per result
module seq_divider #(
    parameter int SUM_W = 30,
    parameter int CNT_W = 20
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    localparam int STEP_W = $clog2(SUM_W + 1);

    logic [CNT_W-1:0] rem, dvsr;
    logic [STEP_W-1:0] steps;
    logic [CNT_W:0] remShift, remSub;
    logic fits;

    // quotient doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom
    always_comb begin
        remShift = {rem, quotient[SUM_W-1]};
        remSub = remShift - {1'b0, dvsr};
        fits = remShift >= {1'b0, dvsr};
    end

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
            rem <= '0;
            dvsr <= '0;
            steps <= '0;
            quotient <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem <= '0;
                dvsr <= divisor;
                quotient <= dividend;
                steps <= STEP_W'(SUM_W);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= fits ? remSub[CNT_W-1:0] : remShift[CNT_W-1:0];
                quotient <= {quotient[SUM_W-2:0], fits};
                steps <= steps - STEP_W'(1);
                busy <= steps != STEP_W'(1);
                done <= steps == STEP_W'(1);
            end
        end
endmodule

// File: rtl/threshold_ctrl.sv
// threshold_ctrl: per-frame mean luminance plus offset, clamped, drives the binariser threshold
module threshold_ctrl import threshold_pkg::*; #(
    parameter int DATA_W = threshold_pkg::DATA_W,
    parameter int CNT_W = threshold_pkg::CNT_W,
    parameter int SUM_W = threshold_pkg::SUM_W,
    parameter int OFFSET = 0,
    parameter int DEF_THRESH = threshold_pkg::DEF_THRESH,
    parameter int MIN_PIX = threshold_pkg::MIN_PIX
) (
    input logic iCLK,
    input logic iRST,
    threshold_ctrl_if.slave bus
);
    localparam logic signed [DATA_W+1:0] OFF = (DATA_W+2)'(OFFSET);

    state_t state, stateNext;
    logic fvalQ, rise, fall, frameStart, frameEnd, enough, start, sat;
    logic divBusy, divDone, busyAll, update, drop;
    logic [SUM_W-1:0] sum, quotient;
    logic [CNT_W-1:0] count;
    logic [DATA_W-1:0] thresh, qLow;
    logic signed [DATA_W+1:0] biased;

    assign rise = bus.iFVAL & ~fvalQ;
    assign fall = ~bus.iFVAL & fvalQ;
    assign frameStart = rise & (state == IDLE);
    assign frameEnd = fall & (state == ACCUM);
    assign sat = &count;
    assign enough = count >= CNT_W'(MIN_PIX);
    assign busyAll = divBusy | divDone;
    assign start = frameEnd & enough & ~busyAll;
    // a mean of DATA_W-bit pixels always fits, but saturate anyway rather than wrap
    assign qLow = |quotient[SUM_W-1:DATA_W] ? '1 : quotient[DATA_W-1:0];
    assign biased = signed'({2'b00, qLow}) + OFF;

    assign bus.oTHRESH = thresh;
    assign bus.oUPDATE = update;
    assign bus.oBUSY = busyAll;
    assign bus.oDROP = drop;

    always_comb
        stateNext = state == IDLE ? (rise ? ACCUM : IDLE) : (fall ? IDLE : ACCUM);

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) state <= IDLE;
        else state <= stateNext;

    always_ff @(posedge iCLK or negedge iRST)
        if (!iRST) begin
            fvalQ <= 1'b0;
            sum <= '0;
            count <= '0;
            thresh <= DATA_W'(DEF_THRESH);
            update <= 1'b0;
            drop <= 1'b0;
        end else begin
            fvalQ <= bus.iFVAL;
            drop <= frameEnd & enough & busyAll;
            update <= divDone & ~bus.iMANUAL;
            if (bus.iMANUAL) thresh <= bus.iMAN_THRESH;
            else if (divDone) thresh <= clamp(biased);
            if (frameStart) begin
                sum <= bus.iDVAL ? SUM_W'(bus.iDATA) : '0;
                count <= CNT_W'(bus.iDVAL);
            end else if (state == ACCUM && !fall && bus.iDVAL && !sat) begin
                sum <= sum + SUM_W'(bus.iDATA);
                count <= count + CNT_W'(1);
            end
        end

    seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) divider (
        .iCLK(iCLK),
        .iRST(iRST),
        .start(start),
        .dividend(sum),
        .divisor(count),
        .busy(divBusy),
        .done(divDone),
        .quotient(quotient)
    );
endmodule
